// File: rtl/router_out_arbiter.sv
// router_out_arbiter: per-output-port packet arbiter for the 16-port router.
// Grants one requesting input port exclusive use of this output port for a
// whole packet. The search for the next owner starts just after the port most
// recently released. A watchdog frees the port if a packet never ends, and a
// saturating counter tallies completed packets for the host.
module router_out_arbiter #(
    parameter int NUM_PORTS = 16,
    parameter int PORT_ID_W = 4,
    parameter int TIMEOUT   = 1024,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] eop,
    input  logic                 enable,
    input  logic                 clr_cnt,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [PORT_ID_W-1:0] gnt_id,
    output logic                 busy,
    output logic                 timeout_pulse,
    output logic [CNT_W-1:0]     pkt_cnt
);

    // The watchdog only has to count up to TIMEOUT-1.
    localparam int WDOG_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDOG_W-1:0]    WDOG_LAST = WDOG_W'(TIMEOUT - 1);
    localparam logic [PORT_ID_W-1:0] LAST_ID   = PORT_ID_W'(NUM_PORTS - 1);
    localparam logic [NUM_PORTS-1:0] ONE_HOT0  = NUM_PORTS'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_PORTS-1:0] gnt_q, gnt_d;
    logic [PORT_ID_W-1:0] gnt_id_q, gnt_id_d;
    logic                 busy_q, busy_d;
    logic                 timeout_pulse_q, timeout_pulse_d;
    logic [CNT_W-1:0]     pkt_cnt_q, pkt_cnt_d;
    logic [PORT_ID_W-1:0] ptr_q, ptr_d;
    logic [WDOG_W-1:0]    wdog_q, wdog_d;

    logic                 pick_valid;
    logic [PORT_ID_W-1:0] pick_id;
    logic                 own_eop;
    logic                 own_req;
    logic                 cnt_inc;

    // Port index base+offs, wrapping modulo NUM_PORTS.
    function automatic logic [PORT_ID_W-1:0] rr_index(input logic [PORT_ID_W-1:0] base,
                                                       input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_PORTS) begin
            sum = sum - NUM_PORTS;
        end
        return PORT_ID_W'(sum);
    endfunction

    assign own_eop = eop[gnt_id_q];
    assign own_req = req[gnt_id_q];

    // Round-robin pick: first requester at or above ptr, wrapping.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!pick_valid && req[rr_index(ptr_q, k)]) begin
                pick_valid = 1'b1;
                pick_id    = rr_index(ptr_q, k);
            end
        end
    end

    // Next-state and registered-output logic for the IDLE/GRANT/GAP machine.
    always_comb begin
        state_d         = state_q;
        gnt_d           = gnt_q;
        gnt_id_d        = gnt_id_q;
        busy_d          = busy_q;
        timeout_pulse_d = 1'b0;
        ptr_d           = ptr_q;
        wdog_d          = wdog_q;
        cnt_inc         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable && pick_valid) begin
                    gnt_d    = ONE_HOT0 << pick_id;
                    gnt_id_d = pick_id;
                    busy_d   = 1'b1;
                    wdog_d   = '0;
                    state_d  = S_GRANT;
                end
            end
            S_GRANT: begin
                // eop beats the watchdog so a packet ending on the last
                // allowed cycle is still counted as complete.
                if (own_eop || !own_req || (wdog_q == WDOG_LAST)) begin
                    cnt_inc         = own_eop;
                    timeout_pulse_d = !own_eop && own_req;
                    gnt_d           = '0;
                    busy_d          = 1'b0;
                    ptr_d           = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + PORT_ID_W'(1);
                    state_d         = S_GAP;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            S_GAP: begin
                // One dead cycle lets the output framer turn around.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Packet counter: host clear has priority, otherwise saturating increment.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (clr_cnt) begin
            pkt_cnt_d = '0;
        end else if (cnt_inc && (pkt_cnt_q != {CNT_W{1'b1}})) begin
            pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            gnt_q           <= '0;
            gnt_id_q        <= '0;
            busy_q          <= 1'b0;
            timeout_pulse_q <= 1'b0;
            pkt_cnt_q       <= '0;
            ptr_q           <= '0;
            wdog_q          <= '0;
        end else begin
            state_q         <= state_d;
            gnt_q           <= gnt_d;
            gnt_id_q        <= gnt_id_d;
            busy_q          <= busy_d;
            timeout_pulse_q <= timeout_pulse_d;
            pkt_cnt_q       <= pkt_cnt_d;
            ptr_q           <= ptr_d;
            wdog_q          <= wdog_d;
        end
    end

    assign gnt           = gnt_q;
    assign gnt_id        = gnt_id_q;
    assign busy          = busy_q;
    assign timeout_pulse = timeout_pulse_q;
    assign pkt_cnt       = pkt_cnt_q;

endmodule

// File: tb/tb_router_out_arbiter.sv
// tb_router_out_arbiter: table-driven packet vectors plus hand-written corner
// sequences. Expected grant ids go into a queue when a request is driven and
// are popped when the arbiter raises busy.
module tb_router_out_arbiter;

    localparam int NP  = 16;
    localparam int IDW = 4;
    localparam int TO  = 8;
    localparam int CW  = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [NP-1:0]  req = '0;
    logic [NP-1:0]  eop = '0;
    logic           enable = 1'b0;
    logic           clr_cnt = 1'b0;
    logic [NP-1:0]  gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic           timeout_pulse;
    logic [CW-1:0]  pkt_cnt;

    // Second instance with a tiny counter to exercise saturation cheaply.
    logic           reset_s = 1'b1;
    logic [NP-1:0]  eop_s;
    logic [NP-1:0]  gnt_s;
    logic [IDW-1:0] gnt_id_s;
    logic           busy_s;
    logic           tp_s;
    logic [2:0]     cnt_s;

    int errors = 0;
    int checks = 0;
    logic [IDW-1:0] exp_q[$];
    logic [IDW-1:0] mon_id;
    logic           busy_prev = 1'b0;

    always #5 clk = ~clk;

    router_out_arbiter #(.NUM_PORTS(NP), .PORT_ID_W(IDW), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .req(req), .eop(eop), .enable(enable), .clr_cnt(clr_cnt),
        .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout_pulse(timeout_pulse), .pkt_cnt(pkt_cnt)
    );

    // Port 0 always requests; every grant ends on its first data cycle.
    assign eop_s = gnt_s;

    router_out_arbiter #(.NUM_PORTS(NP), .PORT_ID_W(IDW), .TIMEOUT(TO), .CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset_s), .req(16'h0001), .eop(eop_s), .enable(1'b1), .clr_cnt(1'b0),
        .gnt(gnt_s), .gnt_id(gnt_id_s), .busy(busy_s), .timeout_pulse(tp_s), .pkt_cnt(cnt_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every new grant must match the oldest expected id.
    always @(negedge clk) begin
        if (!reset) begin
            check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            if (busy && !busy_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: got gnt_id %0d expected no grant", gnt_id);
                end else begin
                    mon_id = exp_q.pop_front();
                    check("sb_gnt_id", 32'(gnt_id), 32'(mon_id));
                    check("sb_gnt", 32'(gnt), 32'(16'h0001 << mon_id));
                    $display("grant: port %0d gnt=%04h pkt_cnt=%0d", gnt_id, gnt, pkt_cnt);
                end
            end
        end
        busy_prev = busy;
    end

    task automatic do_reset();
        reset   = 1'b1;
        req     = '0;
        eop     = '0;
        clr_cnt = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Wait (bounded) for busy; optionally check how many negedges it took.
    task automatic wait_grant(input int exp_lat, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!busy && n < 12);
        if (!busy) begin
            check({name, "_grant_seen"}, 32'(busy), 32'd1);
            exp_q.delete();
        end else if (exp_lat != 0) begin
            check({name, "_latency"}, 32'(n), 32'(exp_lat));
        end
    endtask

    // Packet of len data cycles starting on the grant cycle.
    task automatic run_packet(input logic [IDW-1:0] id, input int len);
        logic [NP-1:0] one;
        one = 16'h0001;
        repeat (len - 1) @(negedge clk);
        eop = one << id;
        @(negedge clk);
        eop = '0;
    endtask

    typedef struct {
        bit             rst;
        logic [NP-1:0]  req;
        int             len;
        int             lat;
        logic [IDW-1:0] id;
        logic [CW-1:0]  cnt;
    } vec_t;

    vec_t vt [0:20];

    initial begin
        int n;
        bit seen;

        // Vector table: single port, strict 16-port rotation, wrapped search.
        vt[0] = '{rst: 1'b1, req: 16'h0001, len: 2, lat: 1, id: 4'd0, cnt: 16'd1};
        for (int i = 0; i < 17; i++) begin
            vt[1 + i] = '{rst: (i == 0), req: 16'hFFFF, len: 1 + (i % 3),
                          lat: (i == 0) ? 1 : 2, id: IDW'(i % 16), cnt: CW'(i + 1)};
        end
        vt[18] = '{rst: 1'b1, req: 16'h0010, len: 1, lat: 1, id: 4'd4, cnt: 16'd1};
        vt[19] = '{rst: 1'b0, req: 16'h0009, len: 1, lat: 2, id: 4'd0, cnt: 16'd2};
        vt[20] = '{rst: 1'b0, req: 16'h0009, len: 2, lat: 2, id: 4'd3, cnt: 16'd3};

        do_reset();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_gnt_id", 32'(gnt_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout", 32'(timeout_pulse), 32'd0);
        check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        @(negedge clk);
        reset_s = 1'b0;

        enable = 1'b1;
        for (int i = 0; i < 21; i++) begin
            if (vt[i].rst) do_reset();
            req = vt[i].req;
            enable = 1'b1;
            exp_q.push_back(vt[i].id);
            wait_grant(vt[i].lat, "vec");
            run_packet(vt[i].id, vt[i].len);
            check("vec_busy_gap", 32'(busy), 32'd0);
            check("vec_gnt_gap", 32'(gnt), 32'd0);
            check("vec_pkt_cnt", 32'(pkt_cnt), 32'(vt[i].cnt));
            check("vec_no_timeout", 32'(timeout_pulse), 32'd0);
        end
        req = '0;

        // Watchdog expiry, foreign eop ignored, then eop exactly on expiry.
        do_reset();
        enable = 1'b1;
        req = 16'h0004;
        exp_q.push_back(4'd2);
        wait_grant(1, "to");
        n = 0;
        seen = 1'b0;
        for (int k = 1; k <= 12 && !seen; k++) begin
            eop = (k == 3) ? 16'h0020 : 16'h0000;
            @(negedge clk);
            if (k == 3) check("foreign_eop_ignored", 32'(busy), 32'd1);
            if (timeout_pulse) begin
                seen = 1'b1;
                n = k;
            end
        end
        eop = '0;
        check("timeout_cycle", 32'(n), 32'(TO));
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_gnt", 32'(gnt), 32'd0);
        check("timeout_pkt_cnt", 32'(pkt_cnt), 32'd0);
        @(negedge clk);
        check("timeout_one_cycle", 32'(timeout_pulse), 32'd0);
        exp_q.push_back(4'd2);
        wait_grant(1, "to_regrant");
        repeat (TO - 1) @(negedge clk);
        eop = 16'h0004;
        @(negedge clk);
        eop = '0;
        check("eop_at_expiry_pulse", 32'(timeout_pulse), 32'd0);
        check("eop_at_expiry_busy", 32'(busy), 32'd0);
        check("eop_at_expiry_cnt", 32'(pkt_cnt), 32'd1);

        // Abort: request withdrawn without eop releases but is not counted.
        req = 16'h0040;
        exp_q.push_back(4'd6);
        wait_grant(0, "abort");
        req = '0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_pulse", 32'(timeout_pulse), 32'd0);
        check("abort_cnt", 32'(pkt_cnt), 32'd1);

        // clr_cnt coincident with a completing eop wins.
        req = 16'h0001;
        exp_q.push_back(4'd0);
        wait_grant(0, "clr");
        eop = 16'h0001;
        clr_cnt = 1'b1;
        @(negedge clk);
        eop = '0;
        clr_cnt = 1'b0;
        req = '0;
        check("clr_wins_cnt", 32'(pkt_cnt), 32'd0);
        check("clr_release", 32'(busy), 32'd0);

        // Enable gating: no grant while disabled, packet survives enable drop.
        do_reset();
        enable = 1'b0;
        req = 16'h0010;
        repeat (5) begin
            @(negedge clk);
            check("disabled_no_grant", 32'(busy), 32'd0);
        end
        enable = 1'b1;
        exp_q.push_back(4'd4);
        wait_grant(1, "en");
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("enable_drop_keeps_grant", 32'(busy), 32'd1);
        eop = 16'h0010;
        @(negedge clk);
        eop = '0;
        check("enable_drop_release", 32'(busy), 32'd0);
        check("enable_drop_cnt", 32'(pkt_cnt), 32'd1);
        repeat (5) @(negedge clk);
        check("disabled_no_regrant", 32'(busy), 32'd0);
        enable = 1'b1;
        exp_q.push_back(4'd4);
        wait_grant(1, "reenable");
        req = '0;
        @(negedge clk);

        // Reset mid-grant clears outputs at once and rewinds the pointer.
        do_reset();
        enable = 1'b1;
        req = 16'h0100;
        exp_q.push_back(4'd8);
        wait_grant(1, "rst_g1");
        run_packet(4'd8, 1);
        exp_q.push_back(4'd8);
        wait_grant(2, "rst_g2");
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_gnt", 32'(gnt), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_cnt", 32'(pkt_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        req = 16'h0300;
        exp_q.push_back(4'd8);
        wait_grant(1, "rst_ptr");
        req = '0;
        @(negedge clk);

        // Saturating counter on the small-counter instance.
        check("sat_cnt_a", 32'(cnt_s), 32'd7);
        repeat (12) @(negedge clk);
        check("sat_cnt_b", 32'(cnt_s), 32'd7);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/router_out_arbiter.md
Name: router_out_arbiter

Overview:
- Per-output-port arbiter for the 16-port router.
- Grants one of NUM_PORTS input ports exclusive use of one output port for a whole packet, using round-robin fairness.
- Enforces a host-configured port enable and a grant watchdog, and keeps a packet counter the host interface can read.
- One instance per router output port, between the input-port frame decoders and the output mux.

Parameters:
NUM_PORTS, 16, number of requesting input ports
PORT_ID_W, 4, width of the granted-port index; must satisfy 2**PORT_ID_W >= NUM_PORTS
TIMEOUT, 1024, maximum cycles a grant may be held without eop
CNT_W, 16, width of the packet counter

Ports:
clk  in  1  router clock
reset  in  1  asynchronous, active-high reset
req  in  NUM_PORTS  req[i]=1: input port i has a packet for this output port; held until granted and done
eop  in  NUM_PORTS  eop[i]=1 for one cycle: last data cycle of port i's packet
enable  in  1  host config: output port enabled for new grants
clr_cnt  in  1  host pulse: clear pkt_cnt
gnt  out  NUM_PORTS  one-hot grant, all zero when idle
gnt_id  out  PORT_ID_W  index of the granted port, valid while busy=1
busy  out  1  output port owned by a requester
timeout_pulse  out  1  one-cycle pulse when the watchdog forces a release
pkt_cnt  out  CNT_W  completed-packet count, saturating

Behaviour:
- Reset values (asynchronous): gnt=0, gnt_id=0, busy=0, timeout_pulse=0, pkt_cnt=0, RR pointer=0, wdog=0, state=IDLE.
- All outputs are registered.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If enable=1 and |req=1 at edge N, pick the first set req[i] searching upward from ptr, wrapping modulo NUM_PORTS.
  - gnt[i], busy and gnt_id=i are visible after edge N (1-cycle latency). Go to GRANT; wdog=0.
  - If enable=0, never grant.
- GRANT:
  - wdog increments each cycle.
  - eop[gnt_id]=1 → gnt=0, busy=0, ptr=gnt_id+1 (wrap NUM_PORTS-1→0), pkt_cnt+1 (saturates at all ones), go to GAP.
  - req[gnt_id] drops with no eop (abort) → release as above, but no count.
  - wdog reaches TIMEOUT-1 with no eop → release, no count, timeout_pulse=1 for one cycle.
  - eop on non-granted ports is ignored.
  - enable dropping during GRANT does not cut the packet.
- GAP: one idle cycle with gnt=0 (output frame turnaround), then IDLE. A new grant is therefore visible at the earliest 2 cycles after the releasing edge.
- Simultaneous eop[gnt_id] and watchdog expiry: eop wins; counted, no timeout_pulse.
- Simultaneous clr_cnt and increment: clr_cnt wins; pkt_cnt=0.
- Single requester: re-granted after each GAP with no starvation. All 16 requesting: grants visit ports in strict rotation.
- gnt is always one-hot or zero; gnt_id is stable for the whole grant.
- Reset asserted mid-grant: all outputs clear immediately; ptr returns to 0.

Test Plan:
- Reset, then req=16'h0001, enable=1 → gnt=16'h0001, gnt_id=0 one cycle later. eop[0] → gnt=0 for GAP, pkt_cnt=1.
- req=16'hFFFF held, eop each time the packet completes → gnt_id sequence 0,1,2,…,15,0. pkt_cnt=17 after 17 packets.
- ptr=5 (after granting 4), req=16'h0009 → grant port 0 (wrap search 5..15 then 0). Next grant is port 3.
- TIMEOUT=8 (test override), req[2] held with no eop → timeout_pulse exactly 8 cycles after the grant, gnt cleared, pkt_cnt unchanged. Repeat with eop[2] on the expiry cycle → counted, no pulse.
- enable=0 with req=16'h0010 → no grant. Drop enable mid-grant → packet completes on eop, no regrant until enable=1.
- pkt_cnt preset near saturation via 16'hFFFF completions → stays 16'hFFFF. clr_cnt coincident with eop → pkt_cnt=0. reset asserted mid-grant → gnt=0, busy=0 immediately, next grant searches from port 0.
